serial_add_sub: RTL and testbench
=================================

Name: serial_add_sub

Overview:
Bit-serial adder/subtractor built around a single registered full-adder cell and a carry flop. It processes one operand bit per clock, LSB first.
- Parallel operands are loaded on a start pulse. After WIDTH cycles the block returns sum, carry-out and signed overflow with a one-cycle done strobe.
- It is the sequential counterpart to the combinational full adder. It is used where area matters more than latency, and it doubles as a carry-chain reference for the adder benches.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while idle
sub  input  1  0 = A+B, 1 = A-B; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while bits are being processed
done  output  1  one-cycle strobe; results valid from this cycle
sum  output  WIDTH  result (A+B or A-B, modulo 2^WIDTH)
cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE. busy=0, done=0, sum=0, cout=0, overflow=0, bit counter=0, carry=0. Takes effect immediately, including mid-operation. Any partial result is discarded and nothing is reported.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge k:
  - capture a into shift reg SA
  - capture b (bitwise inverted if sub=1) into shift reg SB
  - carry <= sub
  - counter <= 0
  - busy <= 1
  - next state RUN
- IDLE, start=0: hold; outputs unchanged.
- RUN, each edge k+1..k+WIDTH:
  - s = SA[0]^SB[0]^carry; carry <= majority(SA[0],SB[0],carry)
  - s shifts into the MSB of result shift reg SR; SA and SB shift right
  - counter increments
  - on the final bit (counter==WIDTH-1): record carry-in to the MSB for overflow
- Completion at edge k+WIDTH, all in that same edge:
  - sum <= final SR, cout <= final carry, overflow <= carry_into_MSB ^ carry_out
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE
- Latency: done is high WIDTH cycles after the edge that sampled start.
- Throughput: one operation per WIDTH+1 cycles. start is accepted at the edge ending the done cycle.
- start while busy is ignored, and so are operand/sub changes during RUN (operands are held internally).
- sum/cout/overflow change only at a completion edge. They hold between operations and are not cleared by a new start.
- done and busy are never high together.
- Wrap-around: the result is modulo 2^WIDTH; cout and overflow report the wrap.

Test Plan:
- WIDTH=8, add 0x0F+0x01 → done exactly 8 cycles after start sampled; sum=0x10, cout=0, overflow=0; busy high 8 cycles.
- Add 0xFF+0x01 → sum=0x00, cout=1, overflow=0. Add 0x7F+0x01 → sum=0x80, cout=0, overflow=1.
- Subtract 0x05-0x07 → sum=0xFE, cout=0 (borrow). Subtract 0x80-0x01 → sum=0x7F, cout=1, overflow=1.
- start re-pulsed, a/b/sub changed, mid-RUN → ignored; first result unchanged. A start at the edge after done → accepted; second result after 8 more cycles.
- rst_n low at bit 4 of an operation → busy, done, sum, cout, overflow all 0 immediately; no done strobe after release. The next op completes correctly.
- WIDTH=4 exhaustive: all a, b, sub combinations → sum/cout/overflow match a golden model; every op has latency 4.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Operands are captured on start; sum/cout/overflow update on the completion edge.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             carry;
  logic             bit_s, bit_c, last;

  always_comb begin
    bit_s = sa[0] ^ sb[0] ^ carry;
    bit_c = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    last  = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Subtraction is A + ~B + 1: B is inverted at capture and carry seeds to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sa    <= a;
          sb    <= sub ? ~b : b;
          carry <= sub;
          cnt   <= '0;
        end
        RUN: begin
          sr    <= {bit_s, sr[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          if (last) begin
            // carry here is the carry into the MSB
            sum      <= {bit_s, sr[WIDTH-1:1]};
            cout     <= bit_c;
            overflow <= carry ^ bit_c;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: WIDTH=8 scenarios plus WIDTH=4 exhaustive sweep.
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 0, sub8 = 0;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic       busy8, done8, cout8, ov8;

  logic       start4 = 0, sub4 = 0;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic       busy4, done4, cout4, ov4;

  int checks = 0;
  int errors = 0;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8));

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ov4));

  // Drive one op from the current negedge; return at the negedge where done is seen.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output int lat, output int bcnt);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     output int lat);
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy8, done8, sum8, cout8, ov8} !== 11'd0) begin
      errors++; $display("FAIL reset8: got %b expected 0", {busy8, done8, sum8, cout8, ov8});
    end
    checks++;
    if ({busy4, done4, sum4, cout4, ov4} !== 7'd0) begin
      errors++; $display("FAIL reset4: got %b expected 0", {busy4, done4, sum4, cout4, ov4});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    int lat, bc;
    op8(8'h0F, 8'h01, 1'b0, lat, bc);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL add_latency: got %0d expected 8", lat); end
    checks++;
    if (bc !== 8) begin errors++; $display("FAIL add_busy_cycles: got %0d expected 8", bc); end
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL done_busy_exclusive: busy=%b expected 0", busy8); end
    checks++;
    if ({sum8, cout8, ov8} !== {8'h10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_0f_01: got %h/%b/%b expected 10/0/0", sum8, cout8, ov8);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done8); end
    checks++;
    if (sum8 !== 8'h10) begin errors++; $display("FAIL sum_hold: got %h expected 10", sum8); end

    op8(8'hFF, 8'h01, 1'b0, lat, bc);
    checks++;
    if ({sum8, cout8, ov8} !== {8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_ff_01: got %h/%b/%b expected 00/1/0", sum8, cout8, ov8);
    end
    @(negedge clk);
    op8(8'h7F, 8'h01, 1'b0, lat, bc);
    checks++;
    if ({sum8, cout8, ov8} !== {8'h80, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_7f_01: got %h/%b/%b expected 80/0/1", sum8, cout8, ov8);
    end
    @(negedge clk);
  endtask

  task automatic test_sub;
    int lat, bc;
    op8(8'h05, 8'h07, 1'b1, lat, bc);
    checks++;
    if ({sum8, cout8, ov8} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_05_07: got %h/%b/%b expected fe/0/0", sum8, cout8, ov8);
    end
    @(negedge clk);
    op8(8'h80, 8'h01, 1'b1, lat, bc);
    checks++;
    if ({sum8, cout8, ov8} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_80_01: got %h/%b/%b expected 7f/1/1", sum8, cout8, ov8);
    end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL sub_latency: got %0d expected 8", lat); end
    @(negedge clk);
  endtask

  task automatic test_ignore_and_back_to_back;
    int lat;
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sub8 = 1'b0;
    lat = 4;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
    checks++;
    if ({sum8, cout8, ov8} !== {8'h46, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ignore_result: got %h/%b/%b expected 46/0/0", sum8, cout8, ov8);
    end
    // start presented during the done cycle is accepted at the edge ending it
    a8 = 8'h50; b8 = 8'h60; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b expected 1", busy8); end
    checks++;
    if (sum8 !== 8'h46) begin errors++; $display("FAIL b2b_sum_held: got %h expected 46", sum8); end
    lat = 0;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    checks++;
    if ({sum8, cout8, ov8} !== {8'hB0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL b2b_result: got %h/%b/%b expected b0/0/1", sum8, cout8, ov8);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen;
    a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8, ov8} !== 11'd0) begin
      errors++; $display("FAIL reset_mid: got %b expected 0", {busy8, done8, sum8, cout8, ov8});
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (done8 || busy8) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_no_done: got %0d active cycles expected 0", seen); end
    op8(8'h20, 8'h22, 1'b0, lat, bc);
    checks++;
    if ({sum8, cout8, ov8, lat} !== {8'h42, 1'b0, 1'b0, 32'd8}) begin
      errors++; $display("FAIL after_reset_op: got %h/%b/%b lat %0d expected 42/0/0 lat 8", sum8, cout8, ov8, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive4;
    int lat;
    logic [4:0] full;
    logic [3:0] bb, es;
    logic ec, eo;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) begin
          bb = 4'(j);
          if (s == 1) full = {1'b0, 4'(i)} + {1'b0, ~bb} + 5'd1;
          else        full = {1'b0, 4'(i)} + {1'b0, bb};
          es = full[3:0];
          ec = full[4];
          if (s == 1) eo = (i[3] != bb[3]) && (es[3] != i[3]);
          else        eo = (i[3] == bb[3]) && (es[3] != i[3]);
          op4(4'(i), bb, s[0], lat);
          checks++;
          if ({sum4, cout4, ov4} !== {es, ec, eo} || lat !== 4) begin
            errors++;
            $display("FAIL exh4 a=%0d b=%0d sub=%0d: got %h/%b/%b lat %0d expected %h/%b/%b lat 4",
                     i, j, s, sum4, cout4, ov4, lat, es, ec, eo);
          end
          @(negedge clk);
        end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_ignore_and_back_to_back;
    test_reset_mid;
    test_exhaustive4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
